// File: rtl/piso_pkg.sv
// piso_pkg: shared constants and types for the parallel-in serial-out bit feeder.
//   WIDTH_DEFAULT : default word width in bits
//   state_t       : feeder FSM states (IDLE, SHIFT)
package piso_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/piso_bit_feeder.sv
// piso_bit_feeder: accepts parallel words over a valid/ready handshake and
// serialises them one bit per cycle, with a one-word holding register so that
// consecutive words stream out with no idle cycle between them.
//
// Ports:
//   clk_i        in   clock, all state changes on the rising edge
//   rst_i        in   synchronous active-high reset
//   word_i       in   WIDTH-bit parallel word
//   word_valid_i in   word_i is valid
//   word_ready_o out  a word can be accepted this cycle (registered decode)
//   data_o       out  serial bit (0 when no word is being shifted)
//   data_valid_o out  data_o carries a word bit this cycle
//   last_o       out  data_o is the final bit of the current word
module piso_bit_feeder
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEFAULT,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             word_valid_i,
  output logic             word_ready_o,
  output logic             data_o,
  output logic             data_valid_o,
  output logic             last_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold_q;
  logic [CW-1:0]    cnt;
  logic             hold_vld;

  logic             accept;
  logic             cnt_last;
  logic             out_bit;
  logic [WIDTH-1:0] shifted;

  // Ready depends only on the hold flag, so a word is accepted whenever the
  // holding register is free; in IDLE and on the last bit it goes straight
  // into the shift register instead.
  assign accept   = word_valid_i && !hold_vld;
  assign cnt_last = (cnt == CNT_LAST);

  always_comb begin
    shifted = shreg;
    out_bit = 1'b0;
    if (MSB_FIRST) begin
      shifted = {shreg[WIDTH-2:0], 1'b0};
      out_bit = shreg[WIDTH-1];
    end else begin
      shifted = {1'b0, shreg[WIDTH-1:1]};
      out_bit = shreg[0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= '0;
      hold_q   <= '0;
      hold_vld <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            shreg <= word_i;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!cnt_last) begin
            shreg <= shifted;
            cnt   <= cnt + 1'b1;
            if (accept) begin
              hold_q   <= word_i;
              hold_vld <= 1'b1;
            end
          end else if (hold_vld) begin
            // Held word takes over on the very next cycle.
            shreg    <= hold_q;
            hold_vld <= 1'b0;
            cnt      <= '0;
          end else if (accept) begin
            // Bypass: word offered on the last bit skips the holding register.
            shreg <= word_i;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign word_ready_o = !hold_vld;
  assign data_valid_o = (state == SHIFT);
  assign data_o       = (state == SHIFT) && out_bit;
  assign last_o       = (state == SHIFT) && cnt_last;

endmodule

// File: tb/tb_piso_bit_feeder.sv
// Testbench for piso_bit_feeder: an MSB-first instance checked every cycle
// against a bit-queue reference model, and an LSB-first instance checked
// against a vector table.
module tb_piso_bit_feeder;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // MSB-first instance
  logic         m_rst, m_valid, m_ready, m_d, m_dv, m_last;
  logic [W-1:0] m_word;
  // LSB-first instance
  logic         l_rst, l_valid, l_ready, l_d, l_dv, l_last;
  logic [W-1:0] l_word;

  piso_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk_i(clk), .rst_i(m_rst), .word_i(m_word), .word_valid_i(m_valid),
    .word_ready_o(m_ready), .data_o(m_d), .data_valid_o(m_dv), .last_o(m_last)
  );

  piso_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_i(clk), .rst_i(l_rst), .word_i(l_word), .word_valid_i(l_valid),
    .word_ready_o(l_ready), .data_o(l_d), .data_valid_o(l_dv), .last_o(l_last)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference model: queue of pending output bits, {data, last}, in emission
  // order. Pending bits beyond one word mean a word is waiting, so ready is low.
  logic [1:0] q[$];

  // Observation statistics gathered by step()
  int          n_dv, n_last, cur_run, max_run;
  logic [31:0] cap;

  task automatic clear_obs();
    n_dv = 0; n_last = 0; cur_run = 0; max_run = 0; cap = '0;
  endtask

  task automatic step(input string tag);
    logic exp_dv, exp_ready, hs;
    @(negedge clk);
    exp_dv    = (q.size() != 0);
    exp_ready = (q.size() <= W);
    chk({tag, ":data_valid"}, 32'(m_dv), 32'(exp_dv));
    chk({tag, ":ready"}, 32'(m_ready), 32'(exp_ready));
    if (exp_dv) begin
      chk({tag, ":data"}, 32'(m_d), 32'(q[0][1]));
      chk({tag, ":last"}, 32'(m_last), 32'(q[0][0]));
    end else begin
      chk({tag, ":data_idle"}, 32'(m_d), 32'd0);
      chk({tag, ":last_idle"}, 32'(m_last), 32'd0);
    end
    if (m_dv === 1'b1) begin
      n_dv++;
      cur_run++;
      if (cur_run > max_run) max_run = cur_run;
      cap = {cap[30:0], m_d};
      if (m_last === 1'b1) n_last++;
    end else begin
      cur_run = 0;
    end
    // Advance model across the coming rising edge
    if (m_rst) begin
      q.delete();
    end else begin
      hs = m_valid && exp_ready;
      if (q.size() != 0) void'(q.pop_front());
      if (hs)
        for (int i = W - 1; i >= 0; i--) q.push_back({m_word[i], 1'(i == 0)});
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         rst;
    logic         valid;
    logic [W-1:0] word;
    logic         chk_en;
    logic         dv;
    logic         d;
    logic         last;
    logic         ready;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [2:0] win;
    logic [7:0] hit_mask;
    int         nbits, nhits;

    m_rst = 1'b1; m_valid = 1'b0; m_word = '0;
    l_rst = 1'b1; l_valid = 1'b0; l_word = '0;
    @(posedge clk); #1;
    m_rst = 1'b0;
    q.delete();

    // LSB-first vectors: 8'h05 -> 1,0,1,0,0,0,0,0
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    for (int r = 0; r < 11; r++) begin
      l_rst = tbl[r].rst; l_valid = tbl[r].valid; l_word = tbl[r].word;
      @(negedge clk);
      if (tbl[r].chk_en) begin
        chk($sformatf("lsb[%0d]:data_valid", r), 32'(l_dv), 32'(tbl[r].dv));
        chk($sformatf("lsb[%0d]:data", r), 32'(l_d), 32'(tbl[r].d));
        chk($sformatf("lsb[%0d]:last", r), 32'(l_last), 32'(tbl[r].last));
        chk($sformatf("lsb[%0d]:ready", r), 32'(l_ready), 32'(tbl[r].ready));
      end
      @(posedge clk); #1;
    end

    // Single word 8'hA5
    clear_obs();
    m_valid = 1'b1; m_word = 8'hA5; step("single");
    m_valid = 1'b0;
    for (int i = 0; i < 10; i++) step("single");
    chk("single:bits", cap[7:0], 32'hA5);
    chk("single:valid_cycles", 32'(n_dv), 32'd8);
    chk("single:last_cycles", 32'(n_last), 32'd1);

    // Back-to-back A5, 5A with valid held over two edges
    clear_obs();
    m_valid = 1'b1; m_word = 8'hA5; step("b2b");
    m_word = 8'h5A; step("b2b");
    m_valid = 1'b0;
    for (int i = 0; i < 18; i++) step("b2b");
    chk("b2b:bits", cap[15:0], 32'hA55A);
    chk("b2b:run", 32'(max_run), 32'd16);

    // Bypass: second word offered only in the last-bit cycle of the first
    clear_obs();
    m_valid = 1'b1; m_word = 8'hA5; step("bypass");
    m_valid = 1'b0;
    for (int i = 0; i < 7; i++) step("bypass");
    m_valid = 1'b1; m_word = 8'h3C; step("bypass");
    m_valid = 1'b0;
    for (int i = 0; i < 10; i++) step("bypass");
    chk("bypass:bits", cap[15:0], 32'hA53C);
    chk("bypass:run", 32'(max_run), 32'd16);

    // Reset mid-word: FF shifting, 00 held, handshake in the reset cycle ignored
    m_valid = 1'b1; m_word = 8'hFF; step("midrst");
    m_word = 8'h00; step("midrst");
    m_valid = 1'b0;
    step("midrst"); step("midrst");
    m_rst = 1'b1; m_valid = 1'b1; m_word = 8'h55; step("midrst");
    m_rst = 1'b0; m_valid = 1'b0;
    clear_obs();
    for (int i = 0; i < 12; i++) step("midrst");
    chk("midrst:bits_after", 32'(n_dv), 32'd0);

    // 8'hAD into a 101 detector: hits at bit indices 2, 4, 7
    clear_obs();
    m_valid = 1'b1; m_word = 8'hAD; step("det");
    m_valid = 1'b0;
    win = '0; hit_mask = '0; nbits = 0; nhits = 0;
    for (int i = 0; i < 10; i++) begin
      step("det");
      if (n_dv > nbits) begin
        win = {win[1:0], cap[0]};
        if (nbits >= 2 && win == 3'b101) begin
          hit_mask[nbits] = 1'b1;
          nhits++;
        end
        nbits = n_dv;
      end
    end
    chk("det:hits", 32'(nhits), 32'd3);
    chk("det:positions", 32'(hit_mask), 32'h94);

    // Random traffic with occasional reset
    for (int i = 0; i < 500; i++) begin
      m_rst   = ($urandom_range(0, 63) == 0);
      m_valid = ($urandom_range(0, 2) != 0);
      m_word  = W'($urandom);
      step("rand");
    end
    m_rst = 1'b0; m_valid = 1'b0;
    for (int i = 0; i < 20; i++) step("drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
